// File: rtl/cluster_size_gate_pkg.sv
// Shared types and defaults for the cluster size gate.
// Holds the 2-bit FSM encoding and the default accept window limits.
package cluster_size_gate_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      OUT  = 2'd2,
      DROP = 2'd3
   } state_t;

   localparam int unsigned DEF_MIN_PTS = 10;
   localparam int unsigned DEF_MAX_PTS = 2000;

endpackage

// File: rtl/cluster_size_gate_if.sv
// Output handshake bundle for accepted clusters.
// master drives valid/count/cid and samples ready; slave is the reverse.
interface cluster_size_gate_if #(
   parameter int N     = 11,
   parameter int CID_W = 8
) ();

   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_count;
   logic [CID_W-1:0] out_cid;

   modport master (
      output out_valid,
      output out_count,
      output out_cid,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_count,
      input  out_cid,
      output out_ready
   );

endinterface

// File: rtl/cluster_size_gate_sat_counter.sv
// Counter with synchronous clear, increment and optional wrap-around.
// Ports: clk, rst (async active-low), inc, clr, wrap_en in; q out.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   input  logic             wrap_en,
   output logic [WIDTH-1:0] q
);

   // A clear coinciding with an increment counts the event
   // into the freshly cleared epoch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= inc ? WIDTH'(1) : '0;
      end else if (inc) begin
         if (&q) begin
            q <= wrap_en ? '0 : q;
         end else begin
            q <= q + WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/cluster_size_gate.sv
// Accepts or rejects finished clusters by point count and emits IDs.
// Ports: clk, rst, ce, cnt_in, eoc, sof in; acc_clr, result (handshake),
// frame_clusters, drop_cnt, overrun out.
module cluster_size_gate
   import cluster_size_gate_pkg::*;
#(
   parameter int          N       = 11,
   parameter int          CID_W   = 8,
   parameter int unsigned MIN_PTS = DEF_MIN_PTS,
   parameter int unsigned MAX_PTS = DEF_MAX_PTS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   input  logic [N-1:0]        cnt_in,
   input  logic                eoc,
   input  logic                sof,
   output logic                acc_clr,
   cluster_size_gate_if.master result,
   output logic [CID_W-1:0]    frame_clusters,
   output logic [CID_W-1:0]    drop_cnt,
   output logic                overrun
);

   localparam logic [N-1:0] MIN_V = N'(MIN_PTS);
   localparam logic [N-1:0] MAX_V = N'(MAX_PTS);

   state_t           state;
   state_t           state_n;
   logic [N-1:0]     cnt_q;
   logic [CID_W-1:0] cid_q;
   logic [CID_W-1:0] cid_out_q;
   logic             acc_clr_q;
   logic             overrun_q;
   logic             take;
   logic             busy_eoc;
   logic             xfer;
   logic             frame_clr;
   logic             drop_inc;
   logic             in_range;

   assign in_range  = (cnt_q >= MIN_V) && (cnt_q <= MAX_V);
   assign take      = ce && eoc && (state == IDLE);
   assign busy_eoc  = ce && eoc && (state != IDLE);
   // The handshake completes even while ce is low.
   assign xfer      = (state == OUT) && result.out_ready;
   assign frame_clr = ce && sof;
   assign drop_inc  = ce && (state == DROP);

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (take) state_n = CLR;
         CLR:  if (ce) state_n = in_range ? OUT : DROP;
         OUT:  if (xfer) state_n = IDLE;
         DROP: if (ce) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         acc_clr_q <= 1'b0;
         cnt_q     <= '0;
         cid_out_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         state     <= state_n;
         acc_clr_q <= (state_n == CLR);
         if (take) begin
            cnt_q <= cnt_in;
         end
         // Snapshot the ID on entry to OUT so a later sof
         // cannot disturb the pending output.
         if (ce && (state == CLR) && in_range) begin
            cid_out_q <= cid_q;
         end
         if (busy_eoc) begin
            overrun_q <= 1'b1;
         end else if (frame_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   sat_counter #(.WIDTH(CID_W)) u_cid (
      .clk     (clk),
      .rst     (rst),
      .inc     (xfer),
      .clr     (frame_clr),
      .wrap_en (1'b1),
      .q       (cid_q)
   );

   sat_counter #(.WIDTH(CID_W)) u_frame (
      .clk     (clk),
      .rst     (rst),
      .inc     (xfer),
      .clr     (frame_clr),
      .wrap_en (1'b1),
      .q       (frame_clusters)
   );

   sat_counter #(.WIDTH(CID_W)) u_drop (
      .clk     (clk),
      .rst     (rst),
      .inc     (drop_inc),
      .clr     (frame_clr),
      .wrap_en (1'b0),
      .q       (drop_cnt)
   );

   assign acc_clr          = acc_clr_q;
   assign overrun          = overrun_q;
   assign result.out_valid = (state == OUT);
   assign result.out_count = cnt_q;
   assign result.out_cid   = cid_out_q;

endmodule

// File: tb/tb_cluster_size_gate.sv
// Directed self-checking bench for cluster_size_gate.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_cluster_size_gate;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        eoc;
   logic        sof;
   logic [10:0] cnt_in;
   logic        acc_clr;
   logic [7:0]  frame_clusters;
   logic [7:0]  drop_cnt;
   logic        overrun;
   int          pass;
   int          total;

   cluster_size_gate_if #(.N(11), .CID_W(8)) bus ();

   cluster_size_gate #(
      .N       (11),
      .CID_W   (8),
      .MIN_PTS (10),
      .MAX_PTS (2000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ce             (ce),
      .cnt_in         (cnt_in),
      .eoc            (eoc),
      .sof            (sof),
      .acc_clr        (acc_clr),
      .result         (bus),
      .frame_clusters (frame_clusters),
      .drop_cnt       (drop_cnt),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ce = 1'b1;
      eoc = 1'b0;
      sof = 1'b0;
      cnt_in = '0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      total++;
      if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.out_valid);
      else pass++;
      total++;
      if (acc_clr !== 1'b0) $display("FAIL rst_acc_clr: got %b want 0", acc_clr);
      else pass++;
      total++;
      if (bus.out_count !== 11'd0) $display("FAIL rst_count: got %0d want 0", bus.out_count);
      else pass++;
      total++;
      if (bus.out_cid !== 8'd0) $display("FAIL rst_cid: got %0d want 0", bus.out_cid);
      else pass++;
      total++;
      if ({frame_clusters, drop_cnt, overrun} !== 17'd0)
         $display("FAIL rst_counters: got %0d/%0d/%b want 0/0/0", frame_clusters, drop_cnt, overrun);
      else pass++;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_accept();
      eoc = 1'b1;
      cnt_in = 11'd150;
      tick();
      eoc = 1'b0;
      total++;
      if (acc_clr !== 1'b1) $display("FAIL acc_clr_t1: got %b want 1", acc_clr);
      else pass++;
      total++;
      if (bus.out_valid !== 1'b0) $display("FAIL valid_t1: got %b want 0", bus.out_valid);
      else pass++;
      tick();
      total++;
      if (bus.out_valid !== 1'b1) $display("FAIL valid_t2: got %b want 1", bus.out_valid);
      else pass++;
      total++;
      if (acc_clr !== 1'b0) $display("FAIL acc_clr_t2: got %b want 0", acc_clr);
      else pass++;
      total++;
      if (bus.out_count !== 11'd150) $display("FAIL accept_count: got %0d want 150", bus.out_count);
      else pass++;
      total++;
      if (bus.out_cid !== 8'd0) $display("FAIL accept_cid: got %0d want 0", bus.out_cid);
      else pass++;
      tick();
      total++;
      if (bus.out_valid !== 1'b0) $display("FAIL accept_done: got %b want 0", bus.out_valid);
      else pass++;
      total++;
      if (frame_clusters !== 8'd1) $display("FAIL accept_frame: got %0d want 1", frame_clusters);
      else pass++;
   endtask

   task automatic test_drop();
      logic [10:0] vals [2];
      vals[0] = 11'd5;
      vals[1] = 11'd2001;
      for (int i = 0; i < 2; i++) begin
         eoc = 1'b1;
         cnt_in = vals[i];
         tick();
         eoc = 1'b0;
         tick();
         total++;
         if (bus.out_valid !== 1'b0) $display("FAIL drop_valid_%0d: got %b want 0", i, bus.out_valid);
         else pass++;
         tick();
         total++;
         if (drop_cnt !== 8'(i + 1)) $display("FAIL drop_cnt_%0d: got %0d want %0d", i, drop_cnt, i + 1);
         else pass++;
      end
      total++;
      if (frame_clusters !== 8'd1) $display("FAIL drop_frame: got %0d want 1", frame_clusters);
      else pass++;
   endtask

   task automatic test_boundary();
      logic [10:0] vals [3];
      logic        acc [3];
      logic [7:0]  exp_cid;
      vals[0] = 11'd10;
      vals[1] = 11'd2000;
      vals[2] = 11'd0;
      acc[0] = 1'b1;
      acc[1] = 1'b1;
      acc[2] = 1'b0;
      exp_cid = 8'd1;
      for (int i = 0; i < 3; i++) begin
         eoc = 1'b1;
         cnt_in = vals[i];
         tick();
         eoc = 1'b0;
         tick();
         total++;
         if (bus.out_valid !== acc[i])
            $display("FAIL bound_valid_%0d: got %b want %b", vals[i], bus.out_valid, acc[i]);
         else pass++;
         if (acc[i]) begin
            total++;
            if (bus.out_count !== vals[i] || bus.out_cid !== exp_cid)
               $display("FAIL bound_out_%0d: got %0d/%0d want %0d/%0d",
                        vals[i], bus.out_count, bus.out_cid, vals[i], exp_cid);
            else pass++;
            exp_cid++;
         end
         tick();
      end
      total++;
      if (drop_cnt !== 8'd3 || frame_clusters !== 8'd3)
         $display("FAIL bound_totals: got %0d/%0d want 3/3", drop_cnt, frame_clusters);
      else pass++;
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      eoc = 1'b1;
      cnt_in = 11'd77;
      tick();
      eoc = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_count !== 11'd77 || bus.out_cid !== 8'd3)
            $display("FAIL hold_%0d: got %b/%0d/%0d want 1/77/3",
                     i, bus.out_valid, bus.out_count, bus.out_cid);
         else pass++;
         eoc = (i == 1);
         cnt_in = 11'd99;
         tick();
         eoc = 1'b0;
      end
      total++;
      if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun);
      else pass++;
      bus.out_ready = 1'b1;
      tick();
      total++;
      if (frame_clusters !== 8'd4) $display("FAIL bp_frame: got %0d want 4", frame_clusters);
      else pass++;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (bus.out_valid !== 1'b0 || acc_clr !== 1'b0)
            $display("FAIL lost_%0d: got %b/%b want 0/0", i, bus.out_valid, acc_clr);
         else pass++;
         tick();
      end
      total++;
      if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", overrun);
      else pass++;
   endtask

   task automatic test_sof_eoc();
      sof = 1'b1;
      eoc = 1'b1;
      cnt_in = 11'd40;
      tick();
      sof = 1'b0;
      eoc = 1'b0;
      total++;
      if ({frame_clusters, drop_cnt, overrun} !== 17'd0)
         $display("FAIL sof_clear: got %0d/%0d/%b want 0/0/0", frame_clusters, drop_cnt, overrun);
      else pass++;
      total++;
      if (acc_clr !== 1'b1) $display("FAIL sof_acc_clr: got %b want 1", acc_clr);
      else pass++;
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_cid !== 8'd0 || bus.out_count !== 11'd40)
         $display("FAIL sof_out: got %b/%0d/%0d want 1/0/40",
                  bus.out_valid, bus.out_cid, bus.out_count);
      else pass++;
      tick();
      total++;
      if (frame_clusters !== 8'd1) $display("FAIL sof_frame: got %0d want 1", frame_clusters);
      else pass++;
   endtask

   task automatic test_sof_during_out();
      bus.out_ready = 1'b0;
      eoc = 1'b1;
      cnt_in = 11'd50;
      tick();
      eoc = 1'b0;
      tick();
      sof = 1'b1;
      tick();
      sof = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_cid !== 8'd1)
         $display("FAIL sofout_hold: got %b/%0d want 1/1", bus.out_valid, bus.out_cid);
      else pass++;
      total++;
      if (frame_clusters !== 8'd0) $display("FAIL sofout_clr: got %0d want 0", frame_clusters);
      else pass++;
      bus.out_ready = 1'b1;
      tick();
      total++;
      if (frame_clusters !== 8'd1 || bus.out_valid !== 1'b0)
         $display("FAIL sofout_acc: got %0d/%b want 1/0", frame_clusters, bus.out_valid);
      else pass++;
   endtask

   task automatic test_ce();
      ce = 1'b0;
      eoc = 1'b1;
      cnt_in = 11'd30;
      tick();
      total++;
      if (acc_clr !== 1'b0 || bus.out_valid !== 1'b0)
         $display("FAIL ce_ignore: got %b/%b want 0/0", acc_clr, bus.out_valid);
      else pass++;
      ce = 1'b1;
      tick();
      eoc = 1'b0;
      ce = 1'b0;
      tick();
      tick();
      total++;
      if (acc_clr !== 1'b1 || bus.out_valid !== 1'b0)
         $display("FAIL ce_hold_clr: got %b/%b want 1/0", acc_clr, bus.out_valid);
      else pass++;
      ce = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_cid !== 8'd1 || bus.out_count !== 11'd30)
         $display("FAIL ce_out: got %b/%0d/%0d want 1/1/30",
                  bus.out_valid, bus.out_cid, bus.out_count);
      else pass++;
      ce = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || frame_clusters !== 8'd2)
         $display("FAIL ce_xfer: got %b/%0d want 0/2", bus.out_valid, frame_clusters);
      else pass++;
      ce = 1'b1;
   endtask

   task automatic test_wrap();
      sof = 1'b1;
      tick();
      sof = 1'b0;
      cnt_in = 11'd100;
      for (int i = 0; i < 255; i++) begin
         eoc = 1'b1;
         tick();
         eoc = 1'b0;
         tick();
         tick();
      end
      total++;
      if (frame_clusters !== 8'd255) $display("FAIL wrap_pre: got %0d want 255", frame_clusters);
      else pass++;
      eoc = 1'b1;
      tick();
      eoc = 1'b0;
      tick();
      total++;
      if (bus.out_cid !== 8'd255) $display("FAIL wrap_cid: got %0d want 255", bus.out_cid);
      else pass++;
      tick();
      total++;
      if (frame_clusters !== 8'd0) $display("FAIL wrap_frame: got %0d want 0", frame_clusters);
      else pass++;
      eoc = 1'b1;
      tick();
      eoc = 1'b0;
      tick();
      total++;
      if (bus.out_cid !== 8'd0) $display("FAIL wrap_next: got %0d want 0", bus.out_cid);
      else pass++;
      tick();
      cnt_in = 11'd3;
      for (int i = 0; i < 260; i++) begin
         eoc = 1'b1;
         tick();
         eoc = 1'b0;
         tick();
         tick();
      end
      total++;
      if (drop_cnt !== 8'd255) $display("FAIL drop_sat: got %0d want 255", drop_cnt);
      else pass++;
   endtask

   task automatic test_reset_mid_out();
      bus.out_ready = 1'b0;
      eoc = 1'b1;
      cnt_in = 11'd60;
      tick();
      eoc = 1'b0;
      tick();
      total++;
      if (bus.out_valid !== 1'b1) $display("FAIL rmid_pre: got %b want 1", bus.out_valid);
      else pass++;
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.out_count !== 11'd0 || bus.out_cid !== 8'd0)
         $display("FAIL rmid_out: got %b/%0d/%0d want 0/0/0",
                  bus.out_valid, bus.out_count, bus.out_cid);
      else pass++;
      total++;
      if ({acc_clr, frame_clusters, drop_cnt, overrun} !== 18'd0)
         $display("FAIL rmid_state: got %b/%0d/%0d/%b want 0/0/0/0",
                  acc_clr, frame_clusters, drop_cnt, overrun);
      else pass++;
      tick();
      tick();
      total++;
      if (acc_clr !== 1'b0 || bus.out_valid !== 1'b0)
         $display("FAIL rmid_hold: got %b/%b want 0/0", acc_clr, bus.out_valid);
      else pass++;
      rst = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      eoc = 1'b1;
      cnt_in = 11'd20;
      tick();
      eoc = 1'b0;
      total++;
      if (acc_clr !== 1'b1) $display("FAIL rpost_clr: got %b want 1", acc_clr);
      else pass++;
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_cid !== 8'd0 || bus.out_count !== 11'd20)
         $display("FAIL rpost_out: got %b/%0d/%0d want 1/0/20",
                  bus.out_valid, bus.out_cid, bus.out_count);
      else pass++;
      tick();
      total++;
      if (frame_clusters !== 8'd1) $display("FAIL rpost_frame: got %0d want 1", frame_clusters);
      else pass++;
   endtask

   initial begin
      pass = 0;
      total = 0;
      test_reset();
      test_accept();
      test_drop();
      test_boundary();
      test_backpressure();
      test_sof_eoc();
      test_sof_during_out();
      test_ce();
      test_wrap();
      test_reset_mid_out();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule

// File: doc/cluster_size_gate.md
CLUSTER_SIZE_GATE -- requirements
Module: cluster_size_gate

Interface
REQ-001 Parameter N, default 11, width of the point count from the per-cluster point accumulator.
REQ-002 Parameter CID_W, default 8, cluster-ID width.
REQ-003 Parameter MIN_PTS, default 10, smallest count that is accepted.
REQ-004 Parameter MAX_PTS, default 2000, largest count that is accepted.
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low.
REQ-007 ce  in  1  clock enable; when low, all state and outputs hold, except that out_ready is still sampled for a pending transfer.
REQ-008 cnt_in  in  N  running point count of the current cluster, taken from the accumulator output.
REQ-009 eoc  in  1  end-of-cluster strobe; cnt_in is final in the same cycle.
REQ-010 sof  in  1  start-of-frame strobe.
REQ-011 acc_clr  out  1  one-cycle clear pulse that drives the accumulator's reset.
REQ-012 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-013 out_count  out  N  accepted cluster size.
REQ-014 out_cid  out  CID_W  accepted cluster ID.
REQ-015 frame_clusters  out  CID_W  number of clusters accepted in the current frame.
REQ-016 drop_cnt  out  CID_W  number of clusters rejected in the current frame; saturates.
REQ-017 overrun  out  1  sticky flag, set when eoc arrives while the block is busy.

Function
REQ-018 The FSM SHALL have four states: IDLE, CLR, OUT, DROP.
REQ-019 IDLE with ce&eoc: the block SHALL latch cnt_in into cnt_q and go to CLR.
REQ-020 CLR: acc_clr SHALL be 1 for exactly that cycle.
REQ-021 CLR exit: if MIN_PTS<=cnt_q<=MAX_PTS (unsigned, inclusive), go to OUT; otherwise go to DROP.
REQ-022 OUT: out_valid SHALL be 1, out_count=cnt_q and out_cid=cid_q, all held stable until out_valid&out_ready.
REQ-023 On out_valid&out_ready: cid_q and frame_clusters SHALL each increment by 1, wrapping to 0 at 2^CID_W-1, and the FSM returns to IDLE.
REQ-024 DROP: lasts one cycle; drop_cnt SHALL increment, saturating at all-ones; the FSM returns to IDLE.
REQ-025 Latency: eoc at cycle t gives acc_clr at t+1 and out_valid at t+2, with all ce high.
REQ-026 eoc in any state other than IDLE SHALL be ignored and SHALL set overrun.
REQ-027 overrun SHALL clear only on reset or sof.
REQ-028 sof SHALL clear cid_q, frame_clusters, drop_cnt and overrun at the next edge, and SHALL not affect the FSM state.
REQ-029 sof and eoc in the same cycle in IDLE: the cluster belongs to the new frame and receives out_cid=0.
REQ-030 sof during OUT: the pending out_cid keeps its old value; the acceptance then increments the cleared counters to 1.
REQ-031 cnt_in equal to 0 SHALL be rejected whenever MIN_PTS>0.
REQ-032 Counter wrap: after 255 accepted clusters in one frame, the next accepted cluster SHALL get out_cid=255, and frame_clusters SHALL then read 0.

Reset
REQ-033 While rst=0, the block SHALL be in state IDLE with acc_clr=0, out_valid=0, out_count=0, out_cid=0, frame_clusters=0, drop_cnt=0 and overrun=0.
REQ-034 A reset in the middle of OUT SHALL drop the pending cluster with no handshake.
REQ-035 After release, the first eoc SHALL be processed normally.
REQ-036 acc_clr SHALL never glitch high while reset is released.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding (2-bit) and the default MIN_PTS and MAX_PTS constants.
REQ-038 There SHALL be one sub-module: sat_counter (parameter width, with inc, clr, wrap_en inputs), used for cid_q, frame_clusters and drop_cnt.
REQ-039 The acc_clr output SHALL come directly from a register.

Verification
REQ-040 cnt_in=150 with eoc and out_ready=1 -> acc_clr at t+1; out_valid at t+2 with out_count=150 and out_cid=0; frame_clusters=1.
REQ-041 cnt_in=5, then cnt_in=2001 -> no out_valid; drop_cnt=2.
REQ-042 cnt_in=10 and cnt_in=2000 -> both accepted (boundary values).
REQ-043 out_ready=0 for 5 cycles with out_valid high, and eoc pulsed during that time -> outputs stable; overrun=1; the second cluster is lost.
REQ-044 sof together with eoc (cnt_in=40) after 3 earlier clusters -> out_cid=0, then frame_clusters=1.
REQ-045 rst=0 asserted while in OUT -> all outputs go to 0 asynchronously; after release, eoc with cnt_in=20 yields out_cid=0.
